// File: rtl/sd_sink_pkg.sv
// Shared constants and types for the SD block sink: block geometry,
// FSM state encoding and the FIFO entry layout.
package sd_sink_pkg;

  localparam int BLOCK_BYTES    = 512;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 8 * BYTES_PER_WORD;
  localparam int BYTE_CNT_W     = $clog2(BLOCK_BYTES);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // One FIFO slot: packed data word plus the end-of-block marker.
  typedef struct packed {
    logic              last;
    logic [WORD_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/sd_block_sink_if.sv
// Output word stream of the SD block sink: valid/ready handshake carrying
// a 32-bit word and an end-of-block marker.
interface sd_block_sink_if;
  import sd_sink_pkg::*;

  logic              m_valid;
  logic              m_ready;
  logic [WORD_W-1:0] m_data;
  logic              m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/sd_sink_fifo.sv
// Synchronous FIFO of {last,data} entries for the SD block sink.
// A push into a full FIFO succeeds only when a pop happens in the same
// cycle; otherwise the entry is dropped and 'drop' is raised for that cycle.
// A pop from an empty FIFO is ignored, so push+pop on empty only writes.
module sd_sink_fifo
  import sd_sink_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push,
  input  logic        pop,
  input  fifo_entry_t wr_entry,
  output fifo_entry_t rd_entry,
  output logic        full,
  output logic        empty,
  output logic        drop
);

  localparam int AW = $clog2(FIFO_DEPTH);

  fifo_entry_t   mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          wr_en;
  logic          rd_en;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign drop  = push && !wr_en;

  // Head is forced to zero when empty so the outputs read 0 in reset/idle.
  assign rd_entry = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; flush empties the FIFO and overrides any push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

endmodule

// File: rtl/sd_block_sink.sv
// SD block sink: packs bytes from the SD reader little-endian into 32-bit
// words, tags the word holding byte 511 of each 512-byte block, and queues
// words in an output FIFO with overflow detection and block accounting.
// Optional feature: define SDSINK_CHECKSUM_EN to add a 16-bit per-block
// byte-sum output 'checksum'.
module sd_block_sink
  import sd_sink_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_in,
  sd_block_sink_if.master        stream,
  output logic                   block_done,
  output logic [31:0]            block_count,
`ifdef SDSINK_CHECKSUM_EN
  output logic [15:0]            checksum,
`endif
  output logic                   overflow
);

  state_t                 state;
  state_t                 state_nxt;
  logic [BYTE_CNT_W-1:0]  byte_cnt;
  logic [1:0]             lane;
  logic                   take;
  logic                   word_end;
  logic                   block_end;

  logic [23:0]            word_p0;
  logic                   vld_p1;
  logic                   last_p1;
  logic [WORD_W-1:0]      word_p1;

  fifo_entry_t            wr_entry;
  fifo_entry_t            rd_entry;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_drop;

  // A byte is accepted only while armed; start and stop both win over it.
  assign lane      = byte_cnt[1:0];
  assign take      = (state == ACTIVE) && byte_valid && !start && !stop;
  assign word_end  = take && (lane == 2'd3);
  assign block_end = take && (byte_cnt == BYTE_CNT_W'(BLOCK_BYTES - 1));

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM next state: start arms (or re-arms), stop disarms.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACTIVE;
      ACTIVE:  if (start) state_nxt = ACTIVE;
               else if (stop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control: byte counter, word-push strobe, block accounting, overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt    <= '0;
      vld_p1      <= 1'b0;
      last_p1     <= 1'b0;
      block_done  <= 1'b0;
      block_count <= '0;
      overflow    <= 1'b0;
    end else begin
      vld_p1     <= 1'b0;
      block_done <= 1'b0;
      if (start) begin
        byte_cnt    <= '0;
        last_p1     <= 1'b0;
        block_count <= '0;
        overflow    <= 1'b0;
      end else begin
        if (stop && (state == ACTIVE)) byte_cnt <= '0;
        else if (take)                 byte_cnt <= byte_cnt + 1'b1;
        if (word_end) begin
          vld_p1  <= 1'b1;
          last_p1 <= block_end;
        end
        // Block done and count land in the same cycle the last word is pushed.
        if (block_end) begin
          block_done  <= 1'b1;
          block_count <= block_count + 32'd1;
        end
        if (fifo_drop) overflow <= 1'b1;
      end
    end
  end

  // Stage p0: collect bytes 0..2 of the word; stage p1: full word ready to push.
  always_ff @(posedge clk) begin
    if (take) begin
      case (lane)
        2'd0:    word_p0[7:0]   <= byte_in;
        2'd1:    word_p0[15:8]  <= byte_in;
        2'd2:    word_p0[23:16] <= byte_in;
        default: ;
      endcase
    end
    if (word_end) word_p1 <= {byte_in, word_p0};
  end

`ifdef SDSINK_CHECKSUM_EN
  logic [15:0] sum_acc;

  // Running byte sum; latched into checksum with the block's final byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_acc  <= '0;
      checksum <= '0;
    end else if (start) begin
      sum_acc  <= '0;
      checksum <= '0;
    end else if (stop && (state == ACTIVE)) begin
      sum_acc  <= '0;
    end else if (take) begin
      if (block_end) begin
        checksum <= sum_acc + 16'(byte_in);
        sum_acc  <= '0;
      end else begin
        sum_acc  <= sum_acc + 16'(byte_in);
      end
    end
  end
`endif

  assign wr_entry.last = last_p1;
  assign wr_entry.data = word_p1;

  sd_sink_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (start),
    .push     (vld_p1),
    .pop      (stream.m_ready),
    .wr_entry (wr_entry),
    .rd_entry (rd_entry),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .drop     (fifo_drop)
  );

  assign stream.m_valid = !fifo_empty;
  assign stream.m_data  = rd_entry.data;
  assign stream.m_last  = rd_entry.last;

endmodule

// File: tb/tb_sd_block_sink.sv
// Directed self-checking bench for sd_block_sink (FIFO_DEPTH=4).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_sd_block_sink;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        block_done;
  logic [31:0] block_count;
  logic        overflow;
`ifdef SDSINK_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int          checks = 0;
  int          errors = 0;

  int          words = 0;
  int          lasts = 0;
  int          last_idx = 0;
  int          dones = 0;
  logic [31:0] first_data = '0;
  logic        mon = 1'b0;

  sd_block_sink_if bus ();

  sd_block_sink #(
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .byte_valid  (byte_valid),
    .byte_in     (byte_in),
    .stream      (bus),
    .block_done  (block_done),
    .block_count (block_count),
`ifdef SDSINK_CHECKSUM_EN
    .checksum    (checksum),
`endif
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_in    = b;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_mon();
    words = 0; lasts = 0; last_idx = 0; dones = 0; first_data = '0;
  endtask

  // Stream monitor: counts accepted words, last markers and block_done pulses.
  always @(negedge clk) begin
    if (mon) begin
      if (bus.m_valid && bus.m_ready) begin
        words++;
        if (words == 1) first_data = bus.m_data;
        if (bus.m_last) begin
          lasts++;
          last_idx = words;
        end
      end
      if (block_done) dones++;
    end
  end

  initial begin
    bus.m_ready = 1'b1;
    ticks(2);
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_m_data", bus.m_data, 32'd0);
    check("rst_m_last", 32'(bus.m_last), 32'd0);
    check("rst_block_done", 32'(block_done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_block_count", block_count, 32'd0);
`ifdef SDSINK_CHECKSUM_EN
    check("rst_checksum", 32'(checksum), 32'd0);
`endif
    rst = 1'b1;
    ticks(1);

    // Scenario 1: one word, 2-cycle latency to m_valid.
    pulse_start();
    put(8'h01); put(8'h02); put(8'h03); put(8'h04);
    check("s1_valid_early", 32'(bus.m_valid), 32'd0);
    ticks(1);
    check("s1_valid", 32'(bus.m_valid), 32'd1);
    check("s1_data", bus.m_data, 32'h04030201);
    check("s1_last", 32'(bus.m_last), 32'd0);
    ticks(1);
    check("s1_popped", 32'(bus.m_valid), 32'd0);

    // Scenario 2: one full block of 8'h01.
    clear_mon();
    mon = 1'b1;
    pulse_start();
    for (int i = 0; i < 512; i++) put(8'h01);
    ticks(4);
    mon = 1'b0;
    check("s2_words", 32'(words), 32'd128);
    check("s2_lasts", 32'(lasts), 32'd1);
    check("s2_last_idx", 32'(last_idx), 32'd128);
    check("s2_done_pulses", 32'(dones), 32'd1);
    check("s2_block_count", block_count, 32'd1);
    check("s2_first_data", first_data, 32'h01010101);
`ifdef SDSINK_CHECKSUM_EN
    check("s2_checksum", 32'(checksum), 32'h0200);
`endif

    // Scenario 3: stalled consumer, six words -> four held, two dropped.
    bus.m_ready = 1'b0;
    pulse_start();
    check("s3_count_cleared", block_count, 32'd0);
    for (int i = 0; i < 24; i++) put(8'(i + 1));
    ticks(3);
    check("s3_overflow", 32'(overflow), 32'd1);
    check("s3_valid", 32'(bus.m_valid), 32'd1);
    check("s3_w1", bus.m_data, 32'h04030201);
    bus.m_ready = 1'b1;
    ticks(1);
    check("s3_w2", bus.m_data, 32'h08070605);
    ticks(1);
    check("s3_w3", bus.m_data, 32'h0c0b0a09);
    ticks(1);
    check("s3_w4", bus.m_data, 32'h100f0e0d);
    ticks(1);
    check("s3_drained", 32'(bus.m_valid), 32'd0);
    check("s3_overflow_sticky", 32'(overflow), 32'd1);
    pulse_start();
    check("s3_overflow_cleared", 32'(overflow), 32'd0);

    // Scenario 4: push and pop in the same cycle while full.
    bus.m_ready = 1'b0;
    for (int i = 0; i < 16; i++) put(8'(i + 1));
    ticks(2);
    check("s4_full_valid", 32'(bus.m_valid), 32'd1);
    for (int i = 16; i < 20; i++) put(8'(i + 1));
    bus.m_ready = 1'b1;
    ticks(1);
    check("s4_no_overflow", 32'(overflow), 32'd0);
    check("s4_w2", bus.m_data, 32'h08070605);
    ticks(1);
    check("s4_w3", bus.m_data, 32'h0c0b0a09);
    ticks(1);
    check("s4_w4", bus.m_data, 32'h100f0e0d);
    ticks(1);
    check("s4_w5", bus.m_data, 32'h14131211);
    ticks(1);
    check("s4_drained", 32'(bus.m_valid), 32'd0);
    check("s4_overflow_end", 32'(overflow), 32'd0);

    // Scenario 5: asynchronous reset mid-block, then a clean block.
    bus.m_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 302; i++) put(8'hAA);
    #2 rst = 1'b0;
    #1;
    check("s5_rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("s5_rst_m_data", bus.m_data, 32'd0);
    check("s5_rst_overflow", 32'(overflow), 32'd0);
    check("s5_rst_block_done", 32'(block_done), 32'd0);
    check("s5_rst_block_count", block_count, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    bus.m_ready = 1'b1;
    ticks(3);
    check("s5_no_word_after_rst", 32'(bus.m_valid), 32'd0);
    check("s5_no_done_after_rst", 32'(block_done), 32'd0);
    clear_mon();
    mon = 1'b1;
    pulse_start();
    for (int i = 0; i < 512; i++) put(8'(i));
    ticks(4);
    mon = 1'b0;
    check("s5_words", 32'(words), 32'd128);
    check("s5_done_pulses", 32'(dones), 32'd1);
    check("s5_block_count", block_count, 32'd1);
    check("s5_first_data", first_data, 32'h03020100);
    check("s5_last_idx", 32'(last_idx), 32'd128);
`ifdef SDSINK_CHECKSUM_EN
    check("s5_checksum", 32'(checksum), 32'hff00);
`endif

    // Scenario 6: bytes in IDLE and coincident with start are ignored.
    put(8'h77); put(8'h78);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    put(8'h55);
    ticks(3);
    check("s6_idle_no_word", 32'(bus.m_valid), 32'd0);
    start      = 1'b1;
    byte_valid = 1'b1;
    byte_in    = 8'h66;
    @(negedge clk);
    start      = 1'b0;
    byte_valid = 1'b0;
    put(8'h11); put(8'h22); put(8'h33); put(8'h44);
    ticks(1);
    check("s6_valid", 32'(bus.m_valid), 32'd1);
    check("s6_data", bus.m_data, 32'h44332211);
    check("s6_block_count", block_count, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
